uart_tx_fifo: RTL and testbench

Output buffer between the brainfuck core's '.' output (byte plus one-cycle push strobe) and the UART transmitter.
- Stores up to 2**DEPTH_LOG2 bytes, so the core stalls only when the buffer is full, not on every character.
- Drives the UART start/data interface itself. It holds the start request until a uartEn cycle samples it, which replaces the separate start-stretching stage on the tx path.

---
 rtl/uart_tx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the core's output strobe and the UART transmitter; owns the start/ack handshake.
// Optional CR-before-LF expansion is enabled by defining UART_TX_FIFO_CRLF_EN.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sysClk,
    input  logic                  reset,
    input  logic                  uartEn,
    input  logic                  wrEn,
    input  logic [7:0]            dataIn,
    output logic                  ready,
    input  logic                  txReady,
    output logic                  startTransmit,
    output logic [7:0]            dataTx,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [2:0]            state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    // UART handshake: startTransmit is held until a cycle with uartEn=1 samples it;
    // the UART then signals acceptance by dropping txReady and completion by raising it.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_ACK        = 3'd2,
        S_DONE       = 3'd3
`ifdef UART_TX_FIFO_CRLF_EN
        ,S_LF_PENDING = 3'd4
`endif
    } state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q;
    logic                  start_q;
    logic [7:0]            data_q;
    state_t                state_q;
    logic                  full, push, pop;
`ifdef UART_TX_FIFO_CRLF_EN
    logic                  lf_q;
`endif

    assign full = (count_q == DEPTH_CNT);
    assign push = wrEn && !full;
    assign pop  = (state_q == S_IDLE) && (count_q != '0) && txReady;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge sysClk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dataIn;
        end
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            data_q     <= 8'h00;
`ifdef UART_TX_FIFO_CRLF_EN
            lf_q       <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (wrEn && full) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        start_q  <= 1'b1;
                        state_q  <= S_START;
`ifdef UART_TX_FIFO_CRLF_EN
                        // An LF is sent as CR first; the LF itself follows from LF_PENDING.
                        if (mem_q[rd_ptr_q] == 8'h0A) begin
                            data_q <= 8'h0D;
                            lf_q   <= 1'b1;
                        end else begin
                            data_q <= mem_q[rd_ptr_q];
                            lf_q   <= 1'b0;
                        end
`else
                        data_q   <= mem_q[rd_ptr_q];
`endif
                    end
                end
                S_START: begin
                    if (uartEn) begin
                        start_q <= 1'b0;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!txReady) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (txReady) begin
`ifdef UART_TX_FIFO_CRLF_EN
                        state_q <= lf_q ? S_LF_PENDING : S_IDLE;
`else
                        state_q <= S_IDLE;
`endif
                    end
                end
`ifdef UART_TX_FIFO_CRLF_EN
                S_LF_PENDING: begin
                    data_q  <= 8'h0A;
                    lf_q    <= 1'b0;
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready         = !full;
    assign startTransmit = start_q;
    assign dataTx        = data_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small UART model that checks every transmitted byte.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int UART_PERIOD = 50;
    localparam int UART_BUSY = 30;

    logic       sysClk = 1'b0;
    logic       reset;
    logic       uartEn;
    logic       wrEn;
    logic [7:0] dataIn;
    logic       ready;
    logic       txReady;
    logic       startTransmit;
    logic [7:0] dataTx;
    logic [DEPTH_LOG2:0] count;
    logic       overflow;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int exp_total = 0;
    int starts = 0;

    logic model_ready = 1'b1;
    logic hold_busy = 1'b0;
    logic uen_hold = 1'b0;
    int   busy_cnt = 0;
    int   div = 0;

    assign txReady = model_ready && !hold_busy;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .sysClk        (sysClk),
        .reset         (reset),
        .uartEn        (uartEn),
        .wrEn          (wrEn),
        .dataIn        (dataIn),
        .ready         (ready),
        .txReady       (txReady),
        .startTransmit (startTransmit),
        .dataTx        (dataTx),
        .count         (count),
        .overflow      (overflow),
        .state_o       (state_o)
    );

    // clock / reset
    always #5 sysClk = ~sysClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysClk);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] b);
`ifdef UART_TX_FIFO_CRLF_EN
        if (b == 8'h0A) begin
            exp_q.push_back(8'h0D);
            exp_total++;
        end
`endif
        exp_q.push_back(b);
        exp_total++;
    endtask

    task automatic drive_push(input logic [7:0] b);
        wrEn = 1'b1;
        dataIn = b;
        expect_byte(b);
        tick();
        wrEn = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && count == '0 && state_o == 3'd0 && txReady) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    // UART model: uartEn pulse every UART_PERIOD cycles; accepts a start, then stays busy.
    initial begin
        uartEn = 1'b0;
        forever begin
            @(negedge sysClk);
            if (reset) begin
                busy_cnt = 0;
                div = 0;
                uartEn = 1'b0;
                model_ready = 1'b1;
            end else begin
                if (busy_cnt > 0) begin
                    model_ready = 1'b0;
                    busy_cnt--;
                end else begin
                    model_ready = 1'b1;
                end
                div = (div == UART_PERIOD - 1) ? 0 : div + 1;
                uartEn = (div == UART_PERIOD - 1) && !uen_hold;
                if (uartEn && startTransmit) begin
                    starts++;
                    busy_cnt = UART_BUSY;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected: got %0h expected none", dataTx);
                    end else begin
                        check("tx_byte", 32'(dataTx), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       acc;
        logic [DEPTH_LOG2:0] exp_count;
        logic       exp_ready;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int n;
        int s0;
        int e0;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(i), 1'b1, 5'(i + 1), (i + 1 < 16), 1'b0};
        end
        vecs[16] = '{1'b1, 8'hFF, 1'b0, 5'd16, 1'b0, 1'b1};

        wrEn = 1'b0;
        dataIn = 8'h00;
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("rst_start", 32'(startTransmit), 32'd0);
        check("rst_data", 32'(dataTx), 32'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        // 1: single byte latency and start hold until uartEn
        tick();
        drive_push(8'h41);
        check("t1_cnt_n1", 32'(count), 32'd1);
        check("t1_start_n1", 32'(startTransmit), 32'd0);
        tick();
        check("t1_start_n2", 32'(startTransmit), 32'd1);
        check("t1_data_n2", 32'(dataTx), 32'h41);
        check("t1_cnt_n2", 32'(count), 32'd0);
        n = 0;
        while (startTransmit && !uartEn && n < 60) begin
            check("t1_data_held", 32'(dataTx), 32'h41);
            tick();
            n++;
        end
        check("t1_uarten_seen", 32'(uartEn), 32'd1);
        check("t1_start_at_en", 32'(startTransmit), 32'd1);
        tick();
        check("t1_start_drop", 32'(startTransmit), 32'd0);
        wait_idle(500);

        // 2: fill to full with the UART held busy, then overflow
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wrEn = vecs[i].wr;
            dataIn = vecs[i].data;
            if (vecs[i].acc) expect_byte(vecs[i].data);
            tick();
            wrEn = 1'b0;
            check("t2_count", 32'(count), 32'(vecs[i].exp_count));
            check("t2_ready", 32'(ready), 32'(vecs[i].exp_ready));
            check("t2_ovf", 32'(overflow), 32'(vecs[i].exp_ovf));
        end
        hold_busy = 1'b0;
        tick();
        check("t2_pop_count", 32'(count), 32'd15);
        check("t2_pop_ready", 32'(ready), 32'd1);
        wait_idle(4000);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);

        // 3: 20 bytes in two bursts, wrapping the pointers
        do_reset();
        s0 = starts;
        e0 = exp_total;
        for (int i = 0; i < 10; i++) drive_push(8'(i * 7 + 3));
        repeat (400) tick();
        for (int i = 10; i < 20; i++) drive_push(8'(i * 7 + 3));
        wait_idle(4000);
        check("t3_ovf", 32'(overflow), 32'd0);
        check("t3_tx_count", 32'(starts - s0), 32'(exp_total - e0));

        // 4: reset while in START with 3 bytes queued
        uen_hold = 1'b1;
        drive_push(8'h11);
        drive_push(8'h12);
        drive_push(8'h13);
        drive_push(8'h14);
        check("t4_pre_start", 32'(startTransmit), 32'd1);
        check("t4_pre_count", 32'(count), 32'd3);
        reset = 1'b1;
        tick();
        check("t4_start", 32'(startTransmit), 32'd0);
        check("t4_count", 32'(count), 32'd0);
        check("t4_data", 32'(dataTx), 32'h00);
        check("t4_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        uen_hold = 1'b0;
        tick();

        // 5: push in the same cycle IDLE pops
        hold_busy = 1'b1;
        drive_push(8'h5A);
        check("t5_cnt_a", 32'(count), 32'd1);
        hold_busy = 1'b0;
        drive_push(8'hA5);
        check("t5_cnt_same", 32'(count), 32'd1);
        check("t5_start", 32'(startTransmit), 32'd1);
        check("t5_data", 32'(dataTx), 32'h5A);
        wait_idle(1000);
        check("t5_cnt_end", 32'(count), 32'd0);

        // 6: line feed handling
        s0 = starts;
        drive_push(8'h0A);
        wait_idle(1000);
`ifdef UART_TX_FIFO_CRLF_EN
        check("t6_starts", 32'(starts - s0), 32'd2);
`else
        check("t6_starts", 32'(starts - s0), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
